// File: rtl/sm3_block_sched.sv
// SM3 block scheduler: steers the bit-serial padded stream into two ping-pong expand
// engines and grants the single compressor to expanded blocks in fill order.
module sm3_block_sched #(
  parameter int unsigned BLOCK_BITS = 512,
  parameter int unsigned CNT_W      = 9
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_pad_bit,
  input  logic             i_pad_en,
  output logic             o_pad_ready,
  output logic             o_exp0_bit,
  output logic             o_exp0_en,
  output logic             o_exp1_bit,
  output logic             o_exp1_en,
  output logic [CNT_W-1:0] o_exp_cnt,
  input  logic             i_exp0_done,
  input  logic             i_exp1_done,
  output logic             o_cmp_start,
  output logic             o_cmp_src,
  output logic             o_cmp_first,
  output logic             o_cmp_last,
  input  logic             i_cmp_done,
  output logic             o_msg_done,
  output logic             o_err_frag
);

  typedef enum logic [2:0] {S_EMPTY, S_FILL, S_EXPAND, S_READY, S_COMPRESS} slot_e;
  typedef enum logic {C_IDLE, C_RUN} cmp_e;

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(BLOCK_BITS - 1);

  slot_e            r_slot [2];
  slot_e            w_slot_nxt [2];
  logic [1:0]       r_last, w_last_nxt, r_resolved, w_resolved_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_wr_ptr, w_wr_nxt, r_rd_ptr, w_rd_nxt;
  logic             r_first_pend, w_first_nxt;
  logic             r_err_frag, w_err_nxt;
  logic             r_res_pend, w_res_pend_nxt, r_res_slot, w_res_slot_nxt;
  cmp_e             r_cst, w_cst_nxt;
  logic             w_cmp_start;
  logic             r_cmp_src, w_src_nxt, r_cmp_first, w_cfirst_nxt, r_cmp_last, w_clast_nxt;
  logic             r_msg_done, w_msg_done_nxt;
  logic             r_exp_en, r_exp_sel, r_exp_bit;
  logic [CNT_W-1:0] r_exp_cnt;
  logic             w_accept;

  assign o_pad_ready = (r_slot[r_wr_ptr] == S_EMPTY) || (r_slot[r_wr_ptr] == S_FILL);
  assign w_accept    = i_pad_en & o_pad_ready;

  always_comb begin
    w_slot_nxt     = r_slot;
    w_last_nxt     = r_last;
    w_resolved_nxt = r_resolved;
    w_cnt_nxt      = r_cnt;
    w_wr_nxt       = r_wr_ptr;
    w_rd_nxt       = r_rd_ptr;
    w_first_nxt    = r_first_pend;
    w_err_nxt      = r_err_frag;
    w_res_pend_nxt = 1'b0;
    w_res_slot_nxt = r_res_slot;
    w_cst_nxt      = r_cst;
    w_cmp_start    = 1'b0;
    w_src_nxt      = r_cmp_src;
    w_cfirst_nxt   = r_cmp_first;
    w_clast_nxt    = r_cmp_last;
    w_msg_done_nxt = 1'b0;

    if (i_exp0_done && r_slot[0] == S_EXPAND) w_slot_nxt[0] = S_READY;
    if (i_exp1_done && r_slot[1] == S_EXPAND) w_slot_nxt[1] = S_READY;

    // pad_en one cycle after a wrap tells whether that block closed the message
    if (r_res_pend) begin
      w_last_nxt[r_res_slot]     = ~i_pad_en;
      w_resolved_nxt[r_res_slot] = 1'b1;
    end

    unique case (r_cst)
      C_IDLE: begin
        if (r_slot[r_rd_ptr] == S_READY && r_resolved[r_rd_ptr]) begin
          w_cmp_start          = 1'b1;
          w_cst_nxt            = C_RUN;
          w_slot_nxt[r_rd_ptr] = S_COMPRESS;
          w_src_nxt            = r_rd_ptr;
          w_cfirst_nxt         = r_first_pend;
          w_clast_nxt          = r_last[r_rd_ptr];
          w_first_nxt          = 1'b0;
        end
      end
      C_RUN: begin
        if (i_cmp_done) begin
          w_cst_nxt            = C_IDLE;
          w_slot_nxt[r_rd_ptr] = S_EMPTY;
          w_rd_nxt             = ~r_rd_ptr;
          if (r_cmp_last) begin
            w_first_nxt    = 1'b1;
            w_msg_done_nxt = 1'b1;
          end
        end
      end
      default: w_cst_nxt = C_IDLE;
    endcase

    if (w_accept) begin
      if (r_cnt == LastCnt) begin
        w_slot_nxt[r_wr_ptr]     = S_EXPAND;
        w_cnt_nxt                = '0;
        w_wr_nxt                 = ~r_wr_ptr;
        w_res_pend_nxt           = 1'b1;
        w_res_slot_nxt           = r_wr_ptr;
        w_resolved_nxt[r_wr_ptr] = 1'b0;
      end else begin
        w_slot_nxt[r_wr_ptr] = S_FILL;
        w_cnt_nxt            = r_cnt + 1'b1;
      end
    end else if (!i_pad_en && r_cnt != '0) begin
      // partial block: discard it and start the next message afresh
      w_err_nxt            = 1'b1;
      w_cnt_nxt            = '0;
      w_slot_nxt[r_wr_ptr] = S_EMPTY;
      w_first_nxt          = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_slot[0]    <= S_EMPTY;
      r_slot[1]    <= S_EMPTY;
      r_last       <= '0;
      r_resolved   <= '0;
      r_cnt        <= '0;
      r_wr_ptr     <= 1'b0;
      r_rd_ptr     <= 1'b0;
      r_first_pend <= 1'b1;
      r_err_frag   <= 1'b0;
      r_res_pend   <= 1'b0;
      r_res_slot   <= 1'b0;
      r_cst        <= C_IDLE;
      r_cmp_src    <= 1'b0;
      r_cmp_first  <= 1'b0;
      r_cmp_last   <= 1'b0;
      r_msg_done   <= 1'b0;
      r_exp_en     <= 1'b0;
      r_exp_sel    <= 1'b0;
      r_exp_bit    <= 1'b0;
      r_exp_cnt    <= '0;
    end else begin
      r_slot       <= w_slot_nxt;
      r_last       <= w_last_nxt;
      r_resolved   <= w_resolved_nxt;
      r_cnt        <= w_cnt_nxt;
      r_wr_ptr     <= w_wr_nxt;
      r_rd_ptr     <= w_rd_nxt;
      r_first_pend <= w_first_nxt;
      r_err_frag   <= w_err_nxt;
      r_res_pend   <= w_res_pend_nxt;
      r_res_slot   <= w_res_slot_nxt;
      r_cst        <= w_cst_nxt;
      r_cmp_src    <= w_src_nxt;
      r_cmp_first  <= w_cfirst_nxt;
      r_cmp_last   <= w_clast_nxt;
      r_msg_done   <= w_msg_done_nxt;
      r_exp_en     <= w_accept;
      r_exp_sel    <= r_wr_ptr;
      r_exp_bit    <= w_accept & i_pad_bit;
      r_exp_cnt    <= w_accept ? r_cnt : '0;
    end
  end

  assign o_exp0_en   = r_exp_en & ~r_exp_sel;
  assign o_exp0_bit  = r_exp_bit & ~r_exp_sel;
  assign o_exp1_en   = r_exp_en & r_exp_sel;
  assign o_exp1_bit  = r_exp_bit & r_exp_sel;
  assign o_exp_cnt   = r_exp_cnt;
  assign o_cmp_start = w_cmp_start;
  assign o_cmp_src   = w_cmp_start ? w_src_nxt    : (r_cst == C_RUN) & r_cmp_src;
  assign o_cmp_first = w_cmp_start ? w_cfirst_nxt : (r_cst == C_RUN) & r_cmp_first;
  assign o_cmp_last  = w_cmp_start ? w_clast_nxt  : (r_cst == C_RUN) & r_cmp_last;
  assign o_msg_done  = r_msg_done;
  assign o_err_frag  = r_err_frag;

endmodule

// File: tb/tb_sm3_block_sched.sv
// Randomized scoreboard bench for sm3_block_sched: stimulus queues expected steering and
// compressor grants; a negedge monitor plays the expand engines and compressor and checks.
module tb_sm3_block_sched;
  localparam int BB = 512;

  logic       clk = 1'b0, rst_n = 1'b0, pad_bit = 1'b0, pad_en = 1'b0;
  logic       exp0_done = 1'b0, exp1_done = 1'b0, cmp_done = 1'b0;
  logic       o_pad_ready, o_exp0_bit, o_exp0_en, o_exp1_bit, o_exp1_en;
  logic [8:0] o_exp_cnt;
  logic       o_cmp_start, o_cmp_src, o_cmp_first, o_cmp_last, o_msg_done, o_err_frag;

  sm3_block_sched #(.BLOCK_BITS(BB), .CNT_W(9)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_pad_bit(pad_bit), .i_pad_en(pad_en),
    .o_pad_ready(o_pad_ready), .o_exp0_bit(o_exp0_bit), .o_exp0_en(o_exp0_en),
    .o_exp1_bit(o_exp1_bit), .o_exp1_en(o_exp1_en), .o_exp_cnt(o_exp_cnt),
    .i_exp0_done(exp0_done), .i_exp1_done(exp1_done), .o_cmp_start(o_cmp_start),
    .o_cmp_src(o_cmp_src), .o_cmp_first(o_cmp_first), .o_cmp_last(o_cmp_last),
    .i_cmp_done(cmp_done), .o_msg_done(o_msg_done), .o_err_frag(o_err_frag)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {logic eng; logic b; logic [8:0] cnt;} steer_t;
  typedef struct packed {logic src; logic first; logic last;} cmp_t;

  steer_t sq[$];
  cmp_t   cq[$];
  int     checks = 0, failures = 0;

  int   exp_tmr[2] = '{-1, -1};
  int   exp_dly[2] = '{3, 3};
  int   cmp_tmr = -1, cmp_dly = 20;
  bit   running = 0, pair_mode = 0, in_reset = 1;
  bit   done_seen[2] = '{0, 0};
  cmp_t cur;
  int   last_done_cyc = -10, first_done_cyc = -1, md_cyc = -10;
  int   md_count = 0, msgs_expected = 0;
  int   first_low_idx = -1, ready_rise_cyc = -1;
  logic model_wr = 1'b0, model_err = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Monitor and responder: expand engines and compressor with programmable latency
  always @(negedge clk) begin
    if (!in_reset) begin
      steer_t e;
      cmp_t   c;
      bit     fire_cmp;
      exp0_done = 1'b0;
      exp1_done = 1'b0;
      cmp_done  = 1'b0;
      fire_cmp  = 1'b0;

      if (o_msg_done) md_count++;
      if (o_msg_done || cyc == md_cyc) chk("msg_done", o_msg_done, cyc == md_cyc);

      for (int n = 0; n < 2; n++) begin
        if (exp_tmr[n] > 0) begin
          exp_tmr[n]--;
          if (exp_tmr[n] == 0) begin
            exp_tmr[n] = -1;
            done_seen[n] = 1'b1;
            if (n == 0) exp0_done = 1'b1;
            else        exp1_done = 1'b1;
            if (n == 1 && pair_mode && running) fire_cmp = 1'b1;
          end
        end
      end
      if (cmp_tmr > 0) begin
        cmp_tmr--;
        if (cmp_tmr == 0) begin
          cmp_tmr  = -1;
          fire_cmp = 1'b1;
        end
      end
      if (fire_cmp) begin
        cmp_done = 1'b1;
        chk("cmp_held", {o_cmp_src, o_cmp_first, o_cmp_last}, cur);
        running = 1'b0;
        last_done_cyc = cyc;
        if (first_done_cyc < 0) first_done_cyc = cyc;
        if (cur.last) md_cyc = cyc + 1;
      end

      if (o_exp0_en || o_exp1_en) begin
        if (sq.size() == 0) fail_now("steer_unexpected");
        else begin
          e = sq.pop_front();
          chk("steer", {o_exp0_en, o_exp0_bit, o_exp1_en, o_exp1_bit, o_exp_cnt},
              {~e.eng, ~e.eng & e.b, e.eng, e.eng & e.b, e.cnt});
          if (o_exp_cnt == 9'd511) exp_tmr[o_exp1_en] = exp_dly[o_exp1_en];
        end
      end

      if (o_cmp_start) begin
        if (running) fail_now("start_while_running");
        if (pair_mode && o_cmp_src) chk("pair_gap", cyc - last_done_cyc, 1);
        chk("start_after_expand", done_seen[o_cmp_src], 1);
        done_seen[o_cmp_src] = 1'b0;
        chk("err_frag", o_err_frag, model_err);
        if (cq.size() == 0) fail_now("start_unexpected");
        else begin
          c = cq.pop_front();
          chk("cmp_rec", {o_cmp_src, o_cmp_first, o_cmp_last}, c);
        end
        running = 1'b1;
        cur     = {o_cmp_src, o_cmp_first, o_cmp_last};
        cmp_tmr = (pair_mode && !o_cmp_src) ? -1 : cmp_dly;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #2;
    in_reset = 1;
    rst_n = 1'b0;
    pad_en = 1'b0;
    pad_bit = 1'b0;
    exp0_done = 1'b0;
    exp1_done = 1'b0;
    cmp_done = 1'b0;
    sq.delete();
    cq.delete();
    exp_tmr = '{-1, -1};
    cmp_tmr = -1;
    running = 0;
    done_seen = '{0, 0};
    md_cyc = -10;
    last_done_cyc = -10;
    model_wr = 1'b0;
    model_err = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    in_reset = 0;
    @(negedge clk);
    chk("reset_outs", {o_exp0_bit, o_exp0_en, o_exp1_bit, o_exp1_en, o_exp_cnt, o_cmp_start,
                       o_cmp_src, o_cmp_first, o_cmp_last, o_msg_done, o_err_frag}, 0);
    chk("reset_ready", o_pad_ready, 1);
  endtask

  // Drives one message; abort_rst pulls reset while pad_en is still high
  task automatic send_msg(input int nbits, input bit abort_rst);
    int   idx = 0, stall = 0;
    int   nblk = nbits / BB;
    bit   saw_low = 0;
    logic w0 = model_wr;
    cmp_t c;
    if (!abort_rst) begin
      for (int k = 0; k < nblk; k++) begin
        c.src   = w0 ^ k[0];
        c.first = (k == 0);
        c.last  = (k == nblk - 1);
        cq.push_back(c);
      end
    end
    while (idx < nbits) begin
      @(negedge clk);
      pad_en  = 1'b1;
      pad_bit = 1'($urandom_range(0, 1));
      if (o_pad_ready) begin
        sq.push_back({model_wr, pad_bit, 9'(idx % BB)});
        if (saw_low && ready_rise_cyc < 0) ready_rise_cyc = cyc;
        idx++;
        if (idx % BB == 0) model_wr = ~model_wr;
        stall = 0;
      end else begin
        if (!saw_low) first_low_idx = idx;
        saw_low = 1;
        stall++;
        if (stall > 20000) begin
          fail_now("pad_ready_timeout");
          break;
        end
      end
    end
    if (abort_rst) do_reset();
    else begin
      @(negedge clk);
      pad_en  = 1'b0;
      pad_bit = 1'b0;
      if (nbits % BB != 0) model_err = 1'b1;
      if (nblk > 0 && nbits % BB == 0) msgs_expected++;
    end
  endtask

  task automatic drain();
    int t = 0;
    while ((sq.size() != 0 || cq.size() != 0 || running) && t < 30000) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    chk("drain", sq.size() + cq.size() + int'(running), 0);
  endtask

  initial begin
    do_reset();

    // one-block message
    exp_dly = '{3, 3};
    cmp_dly = 20;
    send_msg(BB, 0);
    drain();

    // three blocks: pad_ready drops at bit 1024 until block 0 completes
    cmp_dly = 600;
    first_low_idx = -1;
    ready_rise_cyc = -1;
    first_done_cyc = -1;
    send_msg(3 * BB, 0);
    drain();
    chk("ready_drop_idx", first_low_idx, 2 * BB);
    chk("ready_rise_gap", ready_rise_cyc - first_done_cyc, 1);

    // engine 1 finishes long before engine 0
    exp_dly = '{800, 5};
    cmp_dly = 10;
    send_msg(2 * BB, 0);
    drain();

    // cmp_done on slot 0 coincides with exp1_done
    pair_mode = 1;
    exp_dly = '{1, 3};
    send_msg(2 * BB, 0);
    drain();
    pair_mode = 0;

    // fragment then a clean message
    send_msg(300, 0);
    repeat (5) @(negedge clk);
    chk("err_frag_set", o_err_frag, 1);
    exp_dly = '{4, 7};
    send_msg(BB, 0);
    drain();
    chk("err_frag_sticky", o_err_frag, 1);

    // reset mid-stream, then a message must restart on engine 0 with first=1
    send_msg(200, 1);
    send_msg(BB, 0);
    drain();

    for (int m = 0; m < 4; m++) begin
      exp_dly[0] = $urandom_range(1, 40);
      exp_dly[1] = $urandom_range(1, 40);
      cmp_dly    = $urandom_range(1, 80);
      send_msg($urandom_range(1, 3) * BB, 0);
      drain();
    end

    chk("msg_done_count", md_count, msgs_expected);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
